uart_rx_fifo: RTL and testbench

- Fabric-side UART receiver: the receiving end of the core's uart_txd serial line, for bring-up monitoring and loopback without the PS UART.
- 16x oversampling, start-bit validation, mid-bit sampling, LSB-first 8-bit frames.
- Completed bytes are buffered in a FIFO and presented on a ready/valid byte interface.
- Lives in the clk50 domain.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_fifo_sync_fifo.sv | 71 +++++++
 rtl/uart_rx_fifo.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the fabric-side UART receiver: FSM states,
// oversampling constants and the prescaler divisor helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Oversampling ratio and the tick counts at which bits are sampled.
    localparam int         OVS       = 16;
    localparam logic [3:0] MID_START = 4'd7;
    localparam logic [3:0] MID_BIT   = 4'd15;

    // Clocks per oversample tick, rounded to nearest and never below 1.
    function automatic int calc_ovs_div(input int clk_hz, input int baud);
        int div;
        div = (clk_hz + (OVS * baud) / 2) / (OVS * baud);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap by simple overflow.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage write; the head entry is read combinationally below.
    // NOTE: storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled UART receiver feeding a byte FIFO with a
// ready/valid output. Frames are 8N1 by default; defining UART_RX_PARITY_EN
// switches to 8E1 with a parity state and a parity_err pulse.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk50,
    input  logic                          rstn50,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err
);

    localparam int             OVS_DIV   = calc_ovs_div(CLK_HZ, BAUD);
    localparam int             PW        = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(OVS_DIV - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_frame_err;
    logic          r_overrun;

    state_t        w_state_nxt;
    logic [PW-1:0] w_presc_nxt;
    logic [3:0]    w_cnt_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_frame_err_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_rxs;
    logic          w_tick;

`ifdef UART_RX_PARITY_EN
    logic          r_par;
    logic          r_parity_err;
    logic          w_par_nxt;
    logic          w_parity_err_nxt;
    logic          w_par_bad;

    // Even parity: data plus parity bit must hold an even number of ones.
    assign w_par_bad = ^{r_shift, r_par};
`endif

    // Two-flop synchronizer on the asynchronous line plus one cycle of edge history.
    always_ff @(posedge clk50) begin
        if (!rstn50) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rxs  = r_sync2;
    assign w_tick = (r_presc == PRESC_MAX);

    // Next-state, bit-timing and sampling decisions for the receive FSM.
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_presc_nxt     = w_tick ? '0 : r_presc + 1'b1;
        w_cnt_nxt       = r_cnt;
        w_bit_nxt       = r_bit;
        w_shift_nxt     = r_shift;
        w_frame_err_nxt = 1'b0;
        w_push          = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt        = r_par;
        w_parity_err_nxt = 1'b0;
`endif
        if (r_state != IDLE && w_tick) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (!w_rxs && r_prev) begin
                    w_presc_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_tick && r_cnt == MID_START) begin
                    if (w_rxs) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (w_tick && r_cnt == MID_BIT) begin
                    w_shift_nxt[r_bit] = w_rxs;
                    w_bit_nxt          = r_bit + 1'b1;
                    if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_tick && r_cnt == MID_BIT) begin
                    w_par_nxt   = w_rxs;
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                // Return to IDLE at mid stop bit so a back-to-back start edge is caught.
                if (w_tick && r_cnt == MID_BIT) begin
                    w_state_nxt = IDLE;
                    if (!w_rxs) begin
                        w_frame_err_nxt = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (w_par_bad) begin
                        w_parity_err_nxt = 1'b1;
                    end
`endif
                    else begin
                        w_push = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state, bit timing and one-cycle error pulse registers.
    always_ff @(posedge clk50) begin
        if (!rstn50) begin
            r_state     <= IDLE;
            r_presc     <= '0;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_presc     <= w_presc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit       <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_push && w_full && !w_pop;
`ifdef UART_RX_PARITY_EN
            r_par        <= w_par_nxt;
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

    assign w_pop = !w_empty && rx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk50),
        .i_rst_n (rstn50),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (rx_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (rx_count)
    );

    assign rx_valid  = !w_empty;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo at CLK_HZ=3.2 MHz, BAUD=100 kbaud (2 clocks per
// oversample tick, 32 clocks per bit). A timestamp-based reference receiver
// and a byte queue predict every output each cycle; directed scenarios add
// literal expectations. Parity scenarios run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;

    localparam int CLK_HZ  = 3200000;
    localparam int BAUD    = 100000;
    localparam int DEPTH   = 16;
    localparam int D       = 2;
    localparam int BITC    = 16 * D;
    localparam int T_START = 8 * D;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS   = 9;
`else
    localparam int NBITS   = 8;
`endif
    localparam int T_STOP  = T_START + BITC * (NBITS + 1);

    logic       clk50 = 1'b0;
    logic       rstn50;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] rx_count;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int n_vec = 0;
    int n_err = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_perr = 0;
    logic cmp_en = 1'b0;
    logic rnd_ready = 1'b0;
    logic [7:0] got[$];

    // Reference model state.
    logic       m_s1 = 1'b1;
    logic       m_s2 = 1'b1;
    logic       m_prev = 1'b0;
    logic       m_busy = 1'b0;
    int         m_t = 0;
    logic [8:0] m_bits = '0;
    logic [7:0] m_q[$];
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_perr = 1'b0;
    logic       m_pop;
    logic       m_push;

    always #5 clk50 = ~clk50;

    uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk50      (clk50),
        .rstn50     (rstn50),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_count   (rx_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference receiver: frame timing measured in clocks from the detected start edge.
    always @(posedge clk50) begin
        if (!rstn50) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_prev = 1'b0;
            m_busy = 1'b0; m_t = 0;
            m_q.delete();
            m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        end else begin
            m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
            m_pop  = (m_q.size() > 0) && rx_ready;
            m_push = 1'b0;
            if (!m_busy) begin
                if (!m_s2 && m_prev) begin
                    m_busy = 1'b1;
                    m_t    = 0;
                end
            end else begin
                m_t++;
                if (m_t == T_START) begin
                    if (m_s2) m_busy = 1'b0;
                end else if (m_t > T_START && m_t < T_STOP && (m_t - T_START) % BITC == 0) begin
                    m_bits[(m_t - T_START) / BITC - 1] = m_s2;
                end else if (m_t == T_STOP) begin
                    m_busy = 1'b0;
                    if (!m_s2) m_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
                    else if (^m_bits) m_perr = 1'b1;
`endif
                    else m_push = 1'b1;
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_bits[7:0]);
                else m_ovr = 1'b1;
            end
            m_prev = m_s2;
            m_s2   = m_s1;
            m_s1   = rxd;
        end
    end

    // Per-cycle comparison of every output against the model, away from the clock edge.
    always @(negedge clk50) begin
        if (cmp_en) begin
            check("rx_valid", rx_valid, m_q.size() > 0);
            check("rx_data", rx_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
            check("rx_count", rx_count, m_q.size());
            check("frame_err", frame_err, m_ferr);
            check("overrun", overrun, m_ovr);
            check("parity_err", parity_err, m_perr);
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (parity_err) n_perr++;
        end
    end

    // Random consumer back-pressure during the random phase.
    always @(posedge clk50) begin
        if (rnd_ready) begin
            #1;
            rx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step();
        @(posedge clk50);
        #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) step();
    endtask

    // Serialize one frame; abort_bit >= 0 asserts reset half-way through that bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip,
                              input int abort_bit);
        logic frame[$];
        logic pbit;
        pbit = (^b) ^ par_flip;
        frame.push_back(1'b0);
        for (int i = 0; i < 8; i++) frame.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
        frame.push_back(pbit);
`endif
        frame.push_back(stop_b);
        foreach (frame[k]) begin
            rxd = frame[k];
            if (k == abort_bit) begin
                repeat (BITC / 2) step();
                rstn50 = 1'b0;
                repeat (2) step();
                rxd    = 1'b1;
                rstn50 = 1'b1;
                return;
            end
            repeat (BITC) step();
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!rx_valid && n < budget) begin
            step();
            n++;
        end
        check("rx_valid_wait", rx_valid, 1'b1);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, o0;
        rstn50   = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        repeat (3) step();
        cmp_en = 1'b1;
        step();
        check("reset_count", rx_count, 0);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 8'h00);
        rstn50 = 1'b1;
        idle(20);

        // 1: single 0x55 frame held in the FIFO.
        send_frame(8'h55, 1'b1, 1'b0, -1);
        wait_valid(50);
        check("t1_data", rx_data, 8'h55);
        check("t1_count", rx_count, 1);
        check("t1_model_head", m_q.size() == 1 ? m_q[0] : 8'hxx, 8'h55);
        check("t1_no_errors", n_ferr + n_ovr + n_perr, 0);
        pop_one();
        check("t1_popped", rx_count, 0);
        idle(20);

        // 2: short low pulse is rejected as a false start.
        rxd = 1'b0;
        repeat (8) step();
        idle(400);
        check("t2_count", rx_count, 0);
        check("t2_no_errors", n_ferr + n_ovr + n_perr, 0);

        // 3: framing error, then a good frame.
        f0 = n_ferr;
        send_frame(8'hA5, 1'b0, 1'b0, -1);
        idle(40);
        check("t3_ferr_pulses", n_ferr - f0, 1);
        check("t3_count", rx_count, 0);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        wait_valid(50);
        check("t3_data", rx_data, 8'h3C);
        pop_one();
        idle(20);

        // 4: overfill by one frame, then drain in order.
        o0 = n_ovr;
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, -1);
            idle(4);
        end
        check("t4_count", rx_count, DEPTH);
        check("t4_overrun_pulses", n_ovr - o0, 1);
        check("t4_model_size", m_q.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            check("t4_pop_data", rx_data, 8'(i));
            pop_one();
        end
        check("t4_empty", rx_valid, 0);
        idle(20);

        // 5: back-to-back frames with the consumer always ready.
        got.delete();
        rx_ready = 1'b1;
        send_frame(8'h12, 1'b1, 1'b0, -1);
        send_frame(8'h34, 1'b1, 1'b0, -1);
        idle(40);
        check("t5_got_size", got.size(), 2);
        if (got.size() == 2) begin
            check("t5_first", got[0], 8'h12);
            check("t5_second", got[1], 8'h34);
        end
        rx_ready = 1'b0;

        // 5b: reset mid-frame with a byte already buffered.
        send_frame(8'h21, 1'b1, 1'b0, -1);
        idle(10);
        check("t5b_buffered", rx_count, 1);
        send_frame(8'h77, 1'b1, 1'b0, 3);
        check("t5b_reset_count", rx_count, 0);
        check("t5b_reset_valid", rx_valid, 0);
        check("t5b_reset_data", rx_data, 8'h00);
        idle(400);
        check("t5b_no_push", rx_count, 0);

`ifdef UART_RX_PARITY_EN
        // 6: parity error discards the byte; correct parity delivers it.
        begin
            int p0;
            p0 = n_perr;
            send_frame(8'h03, 1'b1, 1'b1, -1);
            idle(20);
            check("t6_perr_pulses", n_perr - p0, 1);
            check("t6_no_push", rx_count, 0);
            send_frame(8'h03, 1'b1, 1'b0, -1);
            wait_valid(50);
            check("t6_data", rx_data, 8'h03);
            pop_one();
            idle(20);
        end
`endif

        // Random frames, glitches, bad stop bits and back-pressure.
        rnd_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            logic stop_b;
            if ($urandom_range(0, 9) == 0) begin
                rxd = 1'b0;
                repeat ($urandom_range(3, 12)) step();
                idle(40);
            end
            stop_b = ($urandom_range(0, 7) != 0);
            send_frame(8'($urandom_range(0, 255)), stop_b, ($urandom_range(0, 7) == 0), -1);
            idle(stop_b ? $urandom_range(0, 40) : $urandom_range(2, 40));
        end
        rnd_ready = 1'b0;
        step();
        rx_ready = 1'b1;
        idle(100);
        check("drained", rx_count, 0);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
